// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter: state encoding and default widths.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_CPU   = 2'd0,
    ST_DMA   = 2'd1,
    ST_YIELD = 2'd2
  } st_t;

  localparam int AW_DEFAULT = 24;

endpackage

// File: rtl/bus_arb_if.sv
// Bus bundle between the CPU/secondary masters and the pins, as seen by bus_arb.
interface bus_arb_if
  import bus_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = AW_DEFAULT
);

  logic [AW-1:0]      cpu_ab;
  logic               cpu_we;
  logic [7:0]         cpu_do;
  logic               cpu_lock;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_ab;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*8-1:0]  req_do;
  logic [NREQ-1:0]    gnt;
  logic               RDY;
  logic [AW-1:0]      AB;
  logic               WE;
  logic [7:0]         DO;
  logic               busy;

  modport slave (
    input  cpu_ab, cpu_we, cpu_do, cpu_lock, req, req_ab, req_we, req_do,
    output gnt, RDY, AB, WE, DO, busy
  );

  modport master (
    output cpu_ab, cpu_we, cpu_do, cpu_lock, req, req_ab, req_we, req_do,
    input  gnt, RDY, AB, WE, DO, busy
  );

endinterface

// File: rtl/bus_arb_rr_pick.sv
// Round-robin finder: first set bit of req scanning upward from rr+1, wrapping.
module bus_arb_rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // Scan from the farthest candidate down so the nearest one after rr wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      cand = IW'((32'(rr) + k) % NREQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arb.sv
// Cycle-stealing arbiter between the CPU and NREQ secondary masters, with
// round-robin fairness and a capped burst followed by a mandatory CPU cycle.
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int BURST_MAX = 4,
  parameter int AW        = AW_DEFAULT
) (
  input  logic      clk,
  input  logic      RST,
  bus_arb_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  st_t             st;
  logic [IW-1:0]   cur;
  logic [IW-1:0]   rr;
  logic [3:0]      cnt;
  logic [NREQ-1:0] gnt_q;
  logic            pick_vld;
  logic [IW-1:0]   pick;

  bus_arb_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req   (bus.req),
    .rr    (rr),
    .valid (pick_vld),
    .idx   (pick)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      st    <= ST_CPU;
      gnt_q <= '0;
      cur   <= '0;
      rr    <= IW'(NREQ - 1);
      cnt   <= '0;
    end else begin
      case (st)
        ST_CPU: begin
          if (pick_vld && !bus.cpu_lock) begin
            st    <= ST_DMA;
            cur   <= pick;
            gnt_q <= NREQ'(1) << pick;
            cnt   <= 4'd1;
          end
        end
        ST_DMA: begin
          if (!bus.req[cur]) begin
            st    <= ST_CPU;
            gnt_q <= '0;
            rr    <= cur;
          end else if (cnt == 4'(BURST_MAX)) begin
            st    <= ST_YIELD;
            gnt_q <= '0;
            rr    <= cur;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_YIELD: st <= ST_CPU;
        default:  st <= ST_CPU;
      endcase
    end
  end

  always_comb begin
    bus.AB = bus.cpu_ab;
    bus.WE = bus.cpu_we;
    bus.DO = bus.cpu_do;
    if (st == ST_DMA) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (cur == IW'(i)) begin
          bus.AB = bus.req_ab[i*AW +: AW];
          bus.WE = bus.req_we[i];
          bus.DO = bus.req_do[i*8 +: 8];
        end
      end
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.RDY  = (st != ST_DMA);
  assign bus.busy = |gnt_q;

endmodule

// File: tb/tb_bus_arb.sv
// Directed-vector bench for bus_arb: two instances, BURST_MAX=4 and BURST_MAX=2.
module tb_bus_arb;

  logic clk = 1'b0;
  logic RST;

  always #5 clk = ~clk;

  bus_arb_if #(.NREQ(2), .AW(24)) bi  ();
  bus_arb_if #(.NREQ(2), .AW(24)) bi2 ();

  bus_arb #(.NREQ(2), .BURST_MAX(4), .AW(24)) u_dut (
    .clk (clk),
    .RST (RST),
    .bus (bi)
  );

  bus_arb #(.NREQ(2), .BURST_MAX(2), .AW(24)) u_dut2 (
    .clk (clk),
    .RST (RST),
    .bus (bi2)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cpu_owns(input string tag);
    check({tag, " gnt"},  32'(bi.gnt), 32'h0);
    check({tag, " RDY"},  32'(bi.RDY), 32'h1);
    check({tag, " busy"}, 32'(bi.busy), 32'h0);
    check({tag, " AB"},   32'(bi.AB), 32'(bi.cpu_ab));
  endtask

  logic [1:0] rr_exp [10] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10,
                              2'b10, 2'b00, 2'b00, 2'b01, 2'b01};

  initial begin
    RST         = 1'b1;
    bi.cpu_ab   = 24'hFF_FFFC;
    bi.cpu_we   = 1'b0;
    bi.cpu_do   = 8'h3C;
    bi.cpu_lock = 1'b0;
    bi.req      = 2'b00;
    bi.req_ab   = {24'h03_4000, 24'h01_2000};
    bi.req_we   = 2'b01;
    bi.req_do   = {8'h5A, 8'hA5};
    bi2.cpu_ab   = 24'h0C_0000;
    bi2.cpu_we   = 1'b0;
    bi2.cpu_do   = 8'h00;
    bi2.cpu_lock = 1'b0;
    bi2.req      = 2'b00;
    bi2.req_ab   = {24'h0B_0000, 24'h0A_0000};
    bi2.req_we   = 2'b00;
    bi2.req_do   = '0;

    // reset then idle
    tick();
    tick();
    RST = 1'b0;
    check_cpu_owns("reset");
    check("reset AB value", 32'(bi.AB), 32'hFF_FFFC);
    check("reset WE", 32'(bi.WE), 32'h0);
    check("reset DO", 32'(bi.DO), 32'h3C);
    tick();
    check_cpu_owns("idle");

    // single steal of three cycles by requester 0
    bi.req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("steal gnt",  32'(bi.gnt), 32'h1);
      check("steal RDY",  32'(bi.RDY), 32'h0);
      check("steal busy", 32'(bi.busy), 32'h1);
      check("steal AB",   32'(bi.AB), 32'h01_2000);
      check("steal WE",   32'(bi.WE), 32'h1);
      check("steal DO",   32'(bi.DO), 32'hA5);
      if (i == 2) bi.req = 2'b00;
    end
    tick();
    check_cpu_owns("steal release");
    check("release DO", 32'(bi.DO), 32'h3C);

    // burst cap: 4 stolen, yield, CPU, then stolen again
    bi.req = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("burst gnt", 32'(bi.gnt), 32'h1);
      check("burst RDY", 32'(bi.RDY), 32'h0);
      if (i == 1) begin
        bi.req_ab[23:0] = 24'h01_2345;
        #1;
        check("burst AB follows", 32'(bi.AB), 32'h01_2345);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      check_cpu_owns("burst yield");
    end
    tick();
    check("burst regrant gnt", 32'(bi.gnt), 32'h1);
    check("burst regrant RDY", 32'(bi.RDY), 32'h0);
    bi.req = 2'b00;
    tick();
    check_cpu_owns("burst release");

    // lock holds off requester 1 until it falls
    bi.req      = 2'b10;
    bi.cpu_lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cpu_owns("lock hold");
    end
    bi.cpu_lock = 1'b0;
    tick();
    check("lock release gnt", 32'(bi.gnt), 32'h2);
    check("lock release RDY", 32'(bi.RDY), 32'h0);
    check("lock release AB",  32'(bi.AB), 32'h03_4000);
    check("lock release WE",  32'(bi.WE), 32'h0);
    bi.req = 2'b00;
    tick();
    check_cpu_owns("lock done");

    // reset mid-burst: last served is 0, burst on 1, reset must restore rr
    bi.req = 2'b01;
    tick();
    check("pre gnt", 32'(bi.gnt), 32'h1);
    bi.req = 2'b00;
    tick();
    bi.req = 2'b10;
    tick();
    check("mid gnt 1st", 32'(bi.gnt), 32'h2);
    tick();
    check("mid gnt 2nd", 32'(bi.gnt), 32'h2);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_cpu_owns("mid reset");
    bi.req = 2'b11;
    tick();
    check("post reset gnt", 32'(bi.gnt), 32'h1);
    bi.req = 2'b00;
    tick();
    check_cpu_owns("post reset release");

    // round robin with BURST_MAX=2
    bi2.req = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("rr gnt %0d", i), 32'(bi2.gnt), 32'(rr_exp[i]));
      check($sformatf("rr RDY %0d", i), 32'(bi2.RDY), (rr_exp[i] == 2'b00) ? 32'h1 : 32'h0);
      check($sformatf("rr AB %0d", i), 32'(bi2.AB),
            (rr_exp[i] == 2'b01) ? 32'h0A_0000 :
            (rr_exp[i] == 2'b10) ? 32'h0B_0000 : 32'h0C_0000);
    end
    bi2.req = 2'b00;
    tick();
    check("rr release gnt", 32'(bi2.gnt), 32'h0);
    check("rr release RDY", 32'(bi2.RDY), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bus_arb.md
Name: bus_arb

Overview:
- Arbitrates the external 24-bit address/data bus between the CPU core and up to NREQ secondary bus masters, such as a DMA engine or a video/refresh fetcher.
- Sits between the CPU core's address generator output (AB, WE, DO) and the pins.
- Steals whole bus cycles by deasserting the CPU's RDY.
- Applies round-robin fairness among the secondary masters and caps burst length so the CPU is never starved.

Parameters:
- NREQ, 2, number of secondary requesters (1..4).
- BURST_MAX, 4, maximum consecutive stolen cycles before one mandatory CPU cycle (1..15).
- AW, 24, address width.

Ports:
- clk  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- cpu_ab  in  AW  CPU address for the current cycle.
- cpu_we  in  1  CPU write enable.
- cpu_do  in  8  CPU write data.
- cpu_lock  in  1  CPU forbids stealing next cycle (RMW, vector fetch, 24-bit operand sequence).
- req  in  NREQ  per-requester bus request, level, held until done.
- req_ab  in  NREQ*AW  packed requester addresses; requester i occupies bits [i*AW +: AW].
- req_we  in  NREQ  per-requester write enable.
- req_do  in  NREQ*8  packed requester write data.
- gnt  out  NREQ  one-hot; requester i owns the bus this cycle.
- RDY  out  1  CPU may advance; 0 = CPU stalled.
- AB  out  AW  bus address.
- WE  out  1  bus write enable.
- DO  out  8  bus write data.
- busy  out  1  a stolen cycle is in progress (equals |gnt).

Behaviour:
- State register: st ∈ {CPU, DMA, YIELD}.
- Also registered:
  - cur: index of the current owner.
  - rr: last-served index.
  - cnt: 4-bit burst counter.
  - gnt: registered, one-hot.
- All outputs are derived from registers and the current-cycle inputs. There is no combinational path from req to RDY or gnt within a cycle.
- Bus mux:
  - st==DMA: AB/WE/DO = req_ab/req_we/req_do slice of cur.
  - Otherwise: cpu_ab/cpu_we/cpu_do.
- RDY = (st != DMA).
- Reset (RST sampled high at posedge), including mid-burst:
  - st=CPU, gnt=0, cur=0, rr=NREQ-1, cnt=0.
  - Therefore RDY=1, busy=0, and the bus follows the CPU the cycle after reset.
- Round-robin pick: first set bit of req scanning from rr+1 upward, wrapping modulo NREQ.
- CPU state, any req set and cpu_lock=0:
  - Next st=DMA, cur=pick, gnt=onehot(pick), cnt=1.
  - If cpu_lock=1 or no req: stay in CPU.
- DMA state, at each posedge. The requester completes one byte transfer per cycle in which its gnt bit is high.
  - RST has priority over everything below.
  - If req[cur]=0: next st=CPU, gnt=0, rr=cur.
  - Else if cnt==BURST_MAX: next st=YIELD, gnt=0, rr=cur.
  - Else: stay in DMA, cnt=cnt+1.
- YIELD state:
  - Exactly one cycle; the CPU owns the bus and RDY=1.
  - Next st=CPU, so new requests can be taken at the following posedge.
  - This guarantees at least one CPU cycle per BURST_MAX stolen cycles, and a second CPU cycle before re-stealing.
- Changes of req in the middle of a burst by non-owners are ignored until the owner releases.
- cpu_lock is only sampled in CPU state; it never aborts a burst in progress.
- When req_ab of the owner changes every cycle, AB follows it in the same cycle; the arbiter does no address arithmetic.
- NREQ=1: rr/pick degenerate to index 0; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the st encoding constants (CPU=2'd0, DMA=2'd1, YIELD=2'd2);
  - the AW default.
- One natural sub-module: rr_pick, a combinational round-robin first-set-bit finder taking (req, rr) and returning (valid, idx).
- The rest stays flat.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, req=0, cpu_ab=24'hFF_FFFC → RDY=1, gnt=0, AB=24'hFFFFFC.
- Single steal: req=2'b01 for 3 cycles, req_ab[0]=24'h01_2000, cpu_lock=0 → one cycle later gnt=01, RDY=0, AB=24'h012000 for 3 cycles; then RDY=1, gnt=0.
- Burst cap: BURST_MAX=4, req=2'b01 held 10 cycles → gnt high 4 cycles, YIELD 1 cycle, CPU 1 cycle (RDY=1 for 2 cycles), then gnt high again.
- Round robin: req=2'b11 held, BURST_MAX=2 → grant sequence 0,0,(yield),1,1,(yield),0,0.
- Lock: cpu_lock=1 for 3 cycles while req=2'b10 → no grant during the lock; gnt=10 on the cycle after cpu_lock falls.
- Reset mid-burst: assert RST on the 2nd stolen cycle → next cycle gnt=0, RDY=1, AB=cpu_ab; first grant after reset goes to requester 0.
